// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: CPU data-memory responder with DMA fill port and cpu_go start pulse
module cpu_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CPUEn,
  input  logic              CPUWrEn,
  input  logic [31:0]       CPUAddr,
  input  logic [31:0]       CPUData,
  output logic [31:0]       CPUOut,
  output logic              CPUValid,
  input  logic              dma_wr_en,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_data,
  input  logic              dma_done,
  output logic              cpu_go,
  input  logic              halt,
  output logic              addr_err,
  output logic              busy
);
  typedef enum logic [1:0] {FILL, IDLE, RD_WAIT, RESP} state_t;
  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d, cpu_idx, wr_idx;
  logic oor_q, oor_d, go_q, go_d, err_q, err_d, hpend_q, hpend_d;
  logic cpu_oor, rd_acc, wr_en, unused_lo;
  logic [31:0] wr_data;
  logic [31:0] mem [2**ADDR_W];
  assign cpu_idx = CPUAddr[ADDR_W+1:2];
  assign cpu_oor = |CPUAddr[31:ADDR_W+2];
  assign unused_lo = ^CPUAddr[1:0];
  always_comb begin
    rd_acc = state_q == IDLE && CPUEn && !halt && !hpend_q;
    wr_en = !rst && (state_q == FILL ? dma_wr_en : CPUWrEn && !cpu_oor);
    wr_idx = state_q == FILL ? dma_addr : cpu_idx;
    wr_data = state_q == FILL ? dma_data : CPUData;
    state_d = state_q;
    case (state_q)
      FILL:    state_d = dma_done ? IDLE : FILL;
      IDLE:    state_d = (halt || hpend_q) ? FILL : !CPUEn ? IDLE : LAT_M1 == 4'd0 ? RESP : RD_WAIT;
      RD_WAIT: state_d = cnt_q == 4'd1 ? RESP : RD_WAIT;
      RESP:    state_d = IDLE;
      default: state_d = FILL;
    endcase
    cnt_d = rd_acc ? LAT_M1 : state_q == RD_WAIT ? cnt_q - 4'd1 : cnt_q;
    idx_d = rd_acc ? cpu_idx : idx_q;
    oor_d = rd_acc ? cpu_oor : oor_q;
    go_d = state_q == FILL && dma_done;
    err_d = err_q || (state_q != FILL && cpu_oor && (rd_acc || CPUWrEn));
    hpend_d = state_q == FILL ? 1'b0 : hpend_q || (halt && (state_q == RD_WAIT || state_q == RESP));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q <= '0;
      idx_q <= '0;
      oor_q <= 1'b0;
      go_q <= 1'b0;
      err_q <= 1'b0;
      hpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      oor_q <= oor_d;
      go_q <= go_d;
      err_q <= err_d;
      hpend_q <= hpend_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end
  assign CPUValid = state_q == RESP;
  assign CPUOut = (CPUValid && !oor_q) ? mem[idx_q] : '0;
  assign cpu_go = go_q;
  assign addr_err = err_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: scoreboard and table-driven bench for two latencies of cpu_mem_responder
module tb_cpu_mem_responder;
  logic clk = 0, rst = 1, cpu_en = 0, cpu_wr = 0, dma_wr = 0, dma_done = 0, halt = 0;
  logic [31:0] cpu_addr = 0, cpu_data = 0, dma_data = 0;
  logic [9:0] dma_addr = 0;
  logic [31:0] out1, out2;
  logic v1, v2, go1, go2, err1, err2, busy1, busy2;
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {int cyc; logic [31:0] data;} exp_t;
  typedef struct {logic rd; logic wr; logic [31:0] addr; logic [31:0] data; logic [31:0] exp; logic err;} vec_t;
  exp_t q[2][$];
  vec_t tbl[13];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cpu_mem_responder #(.ADDR_W(10), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .CPUEn(cpu_en), .CPUWrEn(cpu_wr), .CPUAddr(cpu_addr), .CPUData(cpu_data),
    .CPUOut(out1), .CPUValid(v1), .dma_wr_en(dma_wr), .dma_addr(dma_addr), .dma_data(dma_data),
    .dma_done(dma_done), .cpu_go(go1), .halt(halt), .addr_err(err1), .busy(busy1)
  );
  cpu_mem_responder #(.ADDR_W(10), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .CPUEn(cpu_en), .CPUWrEn(cpu_wr), .CPUAddr(cpu_addr), .CPUData(cpu_data),
    .CPUOut(out2), .CPUValid(v2), .dma_wr_en(dma_wr), .dma_addr(dma_addr), .dma_data(dma_data),
    .dma_done(dma_done), .cpu_go(go2), .halt(halt), .addr_err(err2), .busy(busy2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic mon(input int i, input logic v, input logic [31:0] d);
    exp_t e;
    if (q[i].size() > 0 && q[i][0].cyc < cyc) begin
      e = q[i].pop_front();
      chk($sformatf("missing_valid_lat%0d", i + 1), 32'(cyc), 32'(e.cyc));
    end
    if (v) begin
      if (q[i].size() == 0) chk($sformatf("unexpected_valid_lat%0d", i + 1), 32'd1, 32'd0);
      else begin
        e = q[i].pop_front();
        chk($sformatf("valid_cycle_lat%0d", i + 1), 32'(cyc), 32'(e.cyc));
        chk($sformatf("cpu_out_lat%0d", i + 1), d, e.data);
      end
    end
  endtask
  always @(negedge clk) begin
    if (cyc > 1) begin
      mon(0, v1, out1);
      mon(1, v2, out2);
      chk("go_valid_exclusive", 32'({go1 & v1, go2 & v2}), 32'd0);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input bit both = 1);
    cpu_en = 1;
    cpu_addr = a;
    q[0].push_back('{cyc + 1, exp});
    if (both) q[1].push_back('{cyc + 2, exp});
    step();
    cpu_en = 0;
  endtask
  task automatic dma(input logic [9:0] a, input logic [31:0] d, input bit done);
    dma_wr = 1;
    dma_addr = a;
    dma_data = d;
    dma_done = done;
    step();
    dma_wr = 0;
    dma_done = 0;
  endtask
  task automatic fill_done(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    chk("busy_before_go", 32'({busy1, busy2}), 32'd3);
    chk("go_before_done", 32'({go1, go2}), 32'd0);
    dma(a, d, 1);
    @(negedge clk);
    chk("cpu_go_pulse", 32'({go1, go2}), 32'd3);
    chk("busy_after_go", 32'({busy1, busy2}), 32'd0);
    @(negedge clk);
    chk("cpu_go_one_cycle", 32'({go1, go2}), 32'd0);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'd33, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'd11, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0016, 32'h0, 32'd55, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_A5A5, 32'h0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_A5A5, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0018, 32'd77, 32'd77, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'd11, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'd33, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0010_0000, 32'h0, 32'h0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'h0010_0004, 32'd123, 32'h0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'd11, 1'b1};
    rst = 1;
    idle(2);
    rst = 0;
    @(negedge clk);
    chk("reset_valid", 32'({v1, v2}), 32'd0);
    chk("reset_out1", out1, 32'd0);
    chk("reset_out2", out2, 32'd0);
    chk("reset_go", 32'({go1, go2}), 32'd0);
    chk("reset_err", 32'({err1, err2}), 32'd0);
    chk("reset_busy", 32'({busy1, busy2}), 32'd3);
    cpu_en = 1;
    cpu_wr = 1;
    cpu_addr = 32'h0;
    cpu_data = 32'd999;
    dma(0, 32'd11, 0);
    cpu_en = 0;
    cpu_wr = 0;
    dma(1, 32'd22, 0);
    dma(2, 32'd33, 0);
    dma(5, 32'd55, 0);
    fill_done(3, 32'd44);
    cpu_wr = 1;
    cpu_addr = 32'h4;
    cpu_data = 32'hDEAD_BEEF;
    idle(3);
    cpu_wr = 0;
    idle(1);
    for (int i = 0; i < 13; i++) begin
      cpu_wr = tbl[i].wr;
      cpu_data = tbl[i].data;
      if (tbl[i].rd) rd(tbl[i].addr, tbl[i].exp);
      else begin
        cpu_addr = tbl[i].addr;
        step();
      end
      cpu_wr = 0;
      idle(3);
      @(negedge clk);
      chk($sformatf("addr_err_vec%0d", i), 32'({err1, err2}), tbl[i].err ? 32'd3 : 32'd0);
    end
    rd(32'h8, 32'd33, 0);
    rst = 1;
    step();
    rst = 0;
    cpu_en = 1;
    cpu_addr = 32'h8;
    idle(2);
    cpu_en = 0;
    @(negedge clk);
    chk("busy_after_rst", 32'({busy1, busy2}), 32'd3);
    chk("err_cleared_by_rst", 32'({err1, err2}), 32'd0);
    fill_done(7, 32'd70);
    rd(32'h8, 32'd33);
    idle(3);
    halt = 1;
    step();
    halt = 0;
    cpu_en = 1;
    cpu_addr = 32'h8;
    step();
    cpu_en = 0;
    @(negedge clk);
    chk("busy_after_halt", 32'({busy1, busy2}), 32'd3);
    dma(2, 32'h333, 0);
    fill_done(3, 32'd44);
    rd(32'h8, 32'h333);
    idle(3);
    rd(32'hC, 32'd44);
    halt = 1;
    step();
    halt = 0;
    idle(3);
    @(negedge clk);
    chk("busy_after_deferred_halt", 32'({busy1, busy2}), 32'd3);
    idle(2);
    chk("pending_responses", 32'(q[0].size() + q[1].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
